// File: rtl/gate_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_chk_pkg
// Description : Shared definitions for the 2-input gate truth-table checker:
//               FSM state encoding, vector indices, common truth tables and
//               a helper that looks up the expected gate output.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gate_chk_pkg;

    // FSM state encoding (3 bits)
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_drive    = 3'd1;
    localparam logic [2:0] c_st_settle_w = 3'd2;
    localparam logic [2:0] c_st_sample   = 3'd3;
    localparam logic [2:0] c_st_finish   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = c_st_idle,
        ST_DRIVE    = c_st_drive,
        ST_SETTLE_W = c_st_settle_w,
        ST_SAMPLE   = c_st_sample,
        ST_FINISH   = c_st_finish
    } state_t;

    // Vector indices, encoded as {A,B}
    localparam logic [1:0] c_vec_00 = 2'b00;
    localparam logic [1:0] c_vec_01 = 2'b01;
    localparam logic [1:0] c_vec_10 = 2'b10;
    localparam logic [1:0] c_vec_11 = 2'b11;

    // Truth tables: bit index = {A,B}
    localparam logic [3:0] c_tt_nor  = 4'b0001;
    localparam logic [3:0] c_tt_and  = 4'b1000;
    localparam logic [3:0] c_tt_or   = 4'b1110;
    localparam logic [3:0] c_tt_xor  = 4'b0110;
    localparam logic [3:0] c_tt_nand = 4'b0111;

    // Width of the settle down-counter
    localparam int unsigned c_settle_w = 4;

    // Expected gate output for a given vector
    function automatic logic f_expected_bit(input logic [3:0] tt, input logic [1:0] vec);
        return tt[vec];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_chk_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : gate_chk_settle_cnt
// Description : Loadable 4-bit down-counter with zero flag. Used to hold the
//               checker in its settle state for a programmable number of
//               cycles after a new vector is driven.
// Ports       : clk      in  1  clock, rising edge
//               rst_n    in  1  asynchronous active-low reset
//               load     in  1  load load_val (has priority over dec)
//               load_val in  4  value to load
//               dec      in  1  decrement (saturates at zero)
//               zero     out 1  counter value is zero
// Revision    : 1.0 - initial release
// ============================================================================
module gate_chk_settle_cnt
    import gate_chk_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [c_settle_w-1:0] load_val,
    input  logic                  dec,
    output logic                  zero
);

    logic [c_settle_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - {{(c_settle_w-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_table_checker
// Description : BIST sequencer/checker for a 2-input combinational gate.
//               On start it drives vectors 00,01,10,11 onto the gate, waits
//               SETTLE cycles per vector, samples the gate output and
//               compares it against EXP_TT. Reports error count, first
//               failing vector and pass/done status.
// Parameters  : EXP_TT  expected output per vector, bit index = {A,B}
//               SETTLE  idle cycles between drive and sample (0..15)
// Ports       : clk      in  1  clock, rising edge
//               rst_n    in  1  asynchronous active-low reset
//               start    in  1  one-cycle pulse, accepted in IDLE only
//               dut_c    in  1  output C of gate under test
//               drv_a    out 1  drives input A of gate under test
//               drv_b    out 1  drives input B of gate under test
//               busy     out 1  run in progress
//               done     out 1  one-cycle pulse at end of run
//               pass     out 1  last run had zero errors
//               err_cnt  out 3  mismatch count of last run (0..4)
//               fail_vld out 1  at least one mismatch in current/last run
//               fail_vec out 2  {A,B} of first mismatching vector
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0]  EXP_TT = c_tt_nor,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_c,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic       fail_vld,
    output logic [1:0] fail_vec
);

    // The counter is loaded with SETTLE-1 in DRIVE and SETTLE_W exits when it
    // reads zero, which yields exactly SETTLE cycles in SETTLE_W.
    localparam bit                  c_has_settle  = (SETTLE != 0);
    localparam logic [c_settle_w-1:0] c_settle_load =
        (SETTLE == 0) ? {c_settle_w{1'b0}} : c_settle_w'(SETTLE - 1);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_vec,      w_vec_nxt;
    logic       r_drv_a,    w_drv_a_nxt;
    logic       r_drv_b,    w_drv_b_nxt;
    logic       r_busy,     w_busy_nxt;
    logic       r_done,     w_done_nxt;
    logic       r_pass,     w_pass_nxt;
    logic [2:0] r_err_cnt,  w_err_cnt_nxt;
    logic       r_fail_vld, w_fail_vld_nxt;
    logic [1:0] r_fail_vec, w_fail_vec_nxt;

    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_zero;
    logic       w_mismatch;

    gate_chk_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (c_settle_load),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // dut_c only matters while in SAMPLE; the case below gates its use.
    assign w_mismatch = (dut_c != f_expected_bit(EXP_TT, r_vec));

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_vec      <= c_vec_00;
            r_drv_a    <= 1'b0;
            r_drv_b    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 3'd0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= c_vec_00;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_drv_a    <= w_drv_a_nxt;
            r_drv_b    <= w_drv_b_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_fail_vld <= w_fail_vld_nxt;
            r_fail_vec <= w_fail_vec_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_drv_a_nxt    = r_drv_a;
        w_drv_b_nxt    = r_drv_b;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_err_cnt_nxt  = r_err_cnt;
        w_fail_vld_nxt = r_fail_vld;
        w_fail_vec_nxt = r_fail_vec;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_DRIVE;
                    w_vec_nxt      = c_vec_00;
                    w_err_cnt_nxt  = 3'd0;
                    w_fail_vld_nxt = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end

            ST_DRIVE: begin
                {w_drv_a_nxt, w_drv_b_nxt} = r_vec;
                if (c_has_settle) begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_SETTLE_W;
                end else begin
                    w_state_nxt = ST_SAMPLE;
                end
            end

            ST_SETTLE_W: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (w_mismatch) begin
                    // At most four samples per run, so 3 bits never wrap.
                    w_err_cnt_nxt = r_err_cnt + 3'd1;
                    if (!r_fail_vld) begin
                        w_fail_vld_nxt = 1'b1;
                        w_fail_vec_nxt = r_vec;
                    end
                end
                if (r_vec == c_vec_11) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_vec_nxt   = r_vec + 2'd1;
                    w_state_nxt = ST_DRIVE;
                end
            end

            ST_FINISH: begin
                // err_cnt already includes the last sample here.
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_pass_nxt  = (r_err_cnt == 3'd0);
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign drv_a    = r_drv_a;
    assign drv_b    = r_drv_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_vld = r_fail_vld;
    assign fail_vec = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_table_checker
// Description : Directed self-checking bench for gate_truth_table_checker.
//               Two instances: SETTLE=2 (u_dut2) and SETTLE=0 (u_dut0), both
//               expecting NOR. A behavioural gate model selected by `mode`
//               (NOR, AND, stuck-0, stuck-1) closes the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start2, start0;
    int   mode;   // 0 NOR, 1 AND, 2 stuck-0, 3 stuck-1

    logic       a2, b2, c2, busy2, done2, pass2, fv2;
    logic [2:0] err2;
    logic [1:0] vec2;
    logic       a0, b0, c0, busy0, done0, pass0, fv0;
    logic [2:0] err0;
    logic [1:0] vec0;

    function automatic logic gate_fn(input int m, input logic a, input logic b);
        case (m)
            0:       return ~(a | b);
            1:       return a & b;
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign c2 = gate_fn(mode, a2, b2);
    assign c0 = gate_fn(mode, a0, b0);

    gate_truth_table_checker #(.EXP_TT(4'b0001), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_c(c2),
        .drv_a(a2), .drv_b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_vld(fv2), .fail_vec(vec2)
    );

    gate_truth_table_checker #(.EXP_TT(4'b0001), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_c(c0),
        .drv_a(a0), .drv_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_vld(fv0), .fail_vec(vec0)
    );

    // Instance selector for the shared tasks: 0 = u_dut2, 1 = u_dut0
    logic       sel;
    logic       m_busy, m_done, m_pass, m_fv;
    logic [2:0] m_err;
    logic [1:0] m_vec, m_drv;
    assign m_busy = sel ? busy0 : busy2;
    assign m_done = sel ? done0 : done2;
    assign m_pass = sel ? pass0 : pass2;
    assign m_fv   = sel ? fv0   : fv2;
    assign m_err  = sel ? err0  : err2;
    assign m_vec  = sel ? vec0  : vec2;
    assign m_drv  = sel ? {a0, b0} : {a2, b2};

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Raises start so the next rising edge is the start edge; returns #1 after it.
    task automatic pulse_start();
        @(negedge clk);
        if (sel) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    // Watches a run from #1 after the start edge. Latency is the number of
    // rising edges from the start edge to the one that raised done (-1 if
    // never). The drive value is captured once per vector, just after DRIVE.
    task automatic wait_done(input int per, input int restart_at,
                             output int lat, output logic [7:0] seq,
                             output int ndone, output logic busy_ok);
        int idx;
        lat = -1; ndone = 0; seq = 8'h00; busy_ok = 1'b1; idx = 0;
        for (int n = 1; n <= 4 * per + 8; n++) begin
            @(posedge clk);
            #1;
            if (n == restart_at) begin
                if (sel) start0 = 1'b1; else start2 = 1'b1;
            end else begin
                start0 = 1'b0;
                start2 = 1'b0;
            end
            if (idx < 4 && ((n - 1) % per) == 0) begin
                seq = {seq[5:0], m_drv};
                idx++;
            end
            if (m_done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (lat < 0 && !m_busy) busy_ok = 1'b0;
        end
    endtask

    int         lat, ndone;
    logic [7:0] seq;
    logic       busy_ok;

    initial begin
        rst_n = 1'b0; start2 = 1'b0; start0 = 1'b0; mode = 0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // ---------------- reset state ----------------
        check("rst_busy",     m_busy, 0);
        check("rst_done",     m_done, 0);
        check("rst_pass",     m_pass, 0);
        check("rst_err_cnt",  m_err,  0);
        check("rst_fail_vld", m_fv,   0);
        check("rst_fail_vec", m_vec,  0);
        check("rst_drv",      m_drv,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- 1: NOR, SETTLE=2 ----------------
        mode = 0; sel = 1'b0;
        pulse_start();
        check("t1_busy_after_start", m_busy, 1);
        wait_done(4, 0, lat, seq, ndone, busy_ok);
        check("t1_drv_sequence", seq, 8'b00_01_10_11);
        check("t1_latency", lat, 17);
        check("t1_done_count", ndone, 1);
        check("t1_busy_held", busy_ok, 1);
        check("t1_pass", m_pass, 1);
        check("t1_err_cnt", m_err, 0);
        check("t1_fail_vld", m_fv, 0);
        check("t1_busy_end", m_busy, 0);
        check("t1_drv_hold", m_drv, 2'b11);

        // ---------------- 2: AND gate vs NOR table ----------------
        mode = 1;
        pulse_start();
        wait_done(4, 0, lat, seq, ndone, busy_ok);
        check("t2_latency", lat, 17);
        check("t2_err_cnt", m_err, 2);
        check("t2_fail_vld", m_fv, 1);
        check("t2_fail_vec", m_vec, 2'b00);
        check("t2_pass", m_pass, 0);

        // ---------------- 3: stuck-at faults ----------------
        mode = 2;
        pulse_start();
        wait_done(4, 0, lat, seq, ndone, busy_ok);
        check("t3_s0_err_cnt", m_err, 1);
        check("t3_s0_fail_vec", m_vec, 2'b00);
        check("t3_s0_pass", m_pass, 0);
        mode = 3;
        pulse_start();
        wait_done(4, 0, lat, seq, ndone, busy_ok);
        check("t3_s1_err_cnt", m_err, 3);
        check("t3_s1_fail_vec", m_vec, 2'b01);
        check("t3_s1_fail_vld", m_fv, 1);

        // ---------------- 6: back-to-back fail -> pass ----------------
        mode = 0;
        pulse_start();
        check("t6_fail_vld_cleared", m_fv, 0);
        check("t6_err_cnt_cleared", m_err, 0);
        check("t6_pass_cleared", m_pass, 0);
        wait_done(4, 0, lat, seq, ndone, busy_ok);
        check("t6_latency", lat, 17);
        check("t6_pass", m_pass, 1);
        check("t6_err_cnt", m_err, 0);

        // ---------------- 4: SETTLE=0, ignored restart ----------------
        sel = 1'b1; mode = 0;
        pulse_start();
        wait_done(2, 3, lat, seq, ndone, busy_ok);
        check("t4_drv_sequence", seq, 8'b00_01_10_11);
        check("t4_latency", lat, 9);
        check("t4_done_count", ndone, 1);
        check("t4_busy_held", busy_ok, 1);
        check("t4_pass", m_pass, 1);

        // ---------------- 5: reset during settle of vector 10 ----------------
        sel = 1'b0; mode = 0;
        pulse_start();
        repeat (9) @(posedge clk);
        #3;
        check("t5_drv_before_reset", m_drv, 2'b10);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", m_busy, 0);
        check("t5_rst_drv", m_drv, 0);
        check("t5_rst_pass", m_pass, 0);
        check("t5_rst_err_cnt", m_err, 0);
        check("t5_rst_fail_vld", m_fv, 0);
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            if (m_done) ndone++;
        end
        check("t5_no_done", ndone, 0);
        check("t5_busy_idle", m_busy, 0);
        pulse_start();
        wait_done(4, 0, lat, seq, ndone, busy_ok);
        check("t5_rerun_latency", lat, 17);
        check("t5_rerun_pass", m_pass, 1);
        check("t5_rerun_err_cnt", m_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
